uart_rx_fifo: RTL

Receive side of the debug UART. It samples the core's serial `uart_tx` line, decodes 8N1 frames and buffers the received bytes in a small show-ahead FIFO. The FIFO has a valid/ready output that simulation monitors and on-device consumers drain. It sits directly downstream of `risc_v` and is clocked from the same domain.

---
 rtl/uart_rx_fifo.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive side of the debug UART. Synchronizes the incoming serial line,
// decodes 8N1 frames and buffers the received bytes in a show-ahead FIFO
// drained through a valid/ready handshake.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   FIFO_DEPTH    byte entries in the FIFO (power of 2, >= 2)
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   uart_rx      serial input, idle high, asynchronous to clk
//   rx_data      byte at the FIFO head (0 while the FIFO is empty)
//   rx_valid     FIFO is non-empty
//   rx_ready     consumer accepts the head byte
//   frame_error  one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: completed byte dropped, FIFO full
//   fifo_count   current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             uart_rx,
    output logic [7:0]                       rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic                             frame_error,
    output logic                             overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          sync_q1;
    logic          line;
    logic          line_prev;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic          timer_done;
    logic          fall_edge;
    logic          push_req;
    logic          stop_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    // -------------------------------------------------------------------------
    // Input synchronizer plus one extra stage for falling-edge detection.
    // All stages reset to the idle level so reset never fakes a start bit.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1   <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_q1   <= uart_rx;
            line      <= sync_q1;
            line_prev <= line;
        end
    end

    assign timer_done = (timer == '0);
    assign fall_edge  = line_prev && !line;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (fall_edge) state_next = START;
            START:     if (timer_done) state_next = line ? IDLE : DATA;
            DATA:      if (timer_done && (bit_idx == 3'd7)) state_next = STOP;
            STOP:      if (timer_done) state_next = line ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (line) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The stop bit is judged mid-bit, so a good frame is
    // pushed early enough to catch a back-to-back start bit.
    // -------------------------------------------------------------------------
    always_comb begin
        push_req = 1'b0;
        stop_bad = 1'b0;
        if ((state == STOP) && timer_done) begin
            push_req = line;
            stop_bad = !line;
        end
    end

    // -------------------------------------------------------------------------
    // Bit timer, bit index and shift register (LSB arrives first)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_edge) timer <= HALF_LOAD;
                end
                START: begin
                    if (timer_done) begin
                        timer   <= BIT_LOAD;
                        bit_idx <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        shift_reg <= {line, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        timer     <= BIT_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (!timer_done) timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to separate full from empty.
    // A push onto a full FIFO still lands when the head is popped in the
    // same cycle, because it reuses the slot being freed.
    // -------------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && rx_ready;
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            frame_error <= stop_bad;
            overrun     <= push_req && fifo_full && !pop;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers alone
    // and the read mux hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

    assign rx_valid   = !fifo_empty;
    assign rx_data    = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign fifo_count = wr_ptr - rd_ptr;

endmodule
